// File: rtl/jtdd2_sndcmd_if.sv
// Main-CPU to sound-CPU command mailbox bus: write side, sound-CPU latch
// side and FIFO status, grouped so both ends share one connection.
interface jtdd2_sndcmd_if #(
  parameter int AW = 2
);
  logic          main_wr;
  logic [7:0]    main_din;
  logic          snd_rd;
  logic          ovf_clr;
  logic [7:0]    snd_latch;
  logic          snd_irq;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;

  // The mailbox itself
  modport slave (
    input  main_wr, main_din, snd_rd, ovf_clr,
    output snd_latch, snd_irq, full, empty, count, overflow
  );

  // The CPUs (or a bench) driving the mailbox
  modport master (
    output main_wr, main_din, snd_rd, ovf_clr,
    input  snd_latch, snd_irq, full, empty, count, overflow
  );
endinterface

// File: rtl/jtdd2_sndcmd.sv
// Sound command mailbox: buffers main-CPU bytes in a small FIFO and presents
// them one at a time to the sound CPU, announcing each with an NMI pulse.
module jtdd2_sndcmd #(
  parameter int AW      = 2,
  parameter int IRQ_LEN = 8,
  parameter int GAP_LEN = 16
) (
  input  logic clk,
  input  logic rst,
  jtdd2_sndcmd_if.slave bus
);

  localparam int DEPTH  = 1 << AW;
  localparam int MAXLEN = (IRQ_LEN > GAP_LEN) ? IRQ_LEN : GAP_LEN;
  localparam int TW     = $clog2(MAXLEN + 1);
  localparam logic [TW-1:0] IRQ_LOAD = TW'(IRQ_LEN);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_LEN);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESENT  = 2'd1,
    WAIT_ACK = 2'd2,
    GAP      = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;

  logic [7:0]      mem [DEPTH];
  logic [7:0]      head;

  logic [AW:0]     wr_ptr_reg, wr_ptr_next;
  logic [AW:0]     rd_ptr_reg, rd_ptr_next;
  logic [AW:0]     count_reg, count_next;
  logic            full_reg, full_next;
  logic            empty_reg, empty_next;
  logic            ovf_reg, ovf_next;

  logic [7:0]      latch_reg, latch_next;
  logic            irq_reg, irq_next;

  logic            rd_l_reg;
  logic            rd_fall;
  logic            pop;
  logic            wr_accept;
  logic            wr_drop;

  // The latch chip-select may stay high for many cycles; only its release
  // counts as "the sound CPU has read the byte".
  assign rd_fall = ~bus.snd_rd & rd_l_reg;
  assign head    = mem[rd_ptr_reg[AW-1:0]];

  // A pop frees the head slot in the same cycle, so a write into a full FIFO
  // is accepted when it coincides with a pop.
  assign wr_accept = bus.main_wr & (~full_reg | pop);
  assign wr_drop   = bus.main_wr & full_reg & ~pop;

  always_comb begin
    wr_ptr_next = wr_ptr_reg + (AW+1)'(wr_accept);
    rd_ptr_next = rd_ptr_reg + (AW+1)'(pop);
    count_next  = wr_ptr_next - rd_ptr_next;
    full_next   = (count_next == FULL_CNT);
    empty_next  = (count_next == '0);
    ovf_next    = ovf_reg;
    if (wr_drop) begin
      ovf_next = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_next = 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    latch_next = latch_reg;
    irq_next   = irq_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty_reg) begin
          state_next = PRESENT;
          latch_next = head;
          irq_next   = 1'b1;
          timer_next = IRQ_LOAD;
        end
      end
      PRESENT: begin
        if (rd_fall) begin
          pop        = 1'b1;
          irq_next   = 1'b0;
          timer_next = GAP_LOAD;
          state_next = GAP;
        end else if (timer_reg <= TW'(1)) begin
          irq_next   = 1'b0;
          timer_next = '0;
          state_next = WAIT_ACK;
        end else begin
          timer_next = timer_reg - TW'(1);
        end
      end
      WAIT_ACK: begin
        if (rd_fall) begin
          pop        = 1'b1;
          timer_next = GAP_LOAD;
          state_next = GAP;
        end
      end
      GAP: begin
        // Holds snd_irq low long enough for the NMI edge detector to re-arm.
        if (timer_reg <= TW'(1)) begin
          timer_next = '0;
          state_next = IDLE;
        end else begin
          timer_next = timer_reg - TW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        irq_next   = 1'b0;
        timer_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      timer_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      ovf_reg    <= 1'b0;
      latch_reg  <= 8'h00;
      irq_reg    <= 1'b0;
      rd_l_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      timer_reg  <= timer_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      full_reg   <= full_next;
      empty_reg  <= empty_next;
      ovf_reg    <= ovf_next;
      latch_reg  <= latch_next;
      irq_reg    <= irq_next;
      rd_l_reg   <= bus.snd_rd;
    end
  end

  // Storage is not reset: stale contents are never visible because the
  // pointers are, and only presented bytes reach snd_latch.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_reg[AW-1:0]] <= bus.main_din;
    end
  end

  assign bus.snd_latch = latch_reg;
  assign bus.snd_irq   = irq_reg;
  assign bus.full      = full_reg;
  assign bus.empty     = empty_reg;
  assign bus.count     = count_reg;
  assign bus.overflow  = ovf_reg;

endmodule

// File: doc/jtdd2_sndcmd.md
# jtdd2_sndcmd

Command mailbox between the main CPU and the sound CPU. It buffers main-CPU command bytes in a small FIFO and presents them one at a time on `snd_latch`. Each presentation is announced with a `snd_irq` pulse; the NMI flip-flop in the sound subsystem triggers on the rising edge of `snd_irq`. A byte is retired only after the sound CPU has read it, so back-to-back commands from the main CPU are no longer lost.

## Interface
Parameters:
- `AW`, 2: FIFO address width; depth is 2^AW bytes.
- `IRQ_LEN`, 8: width of the `snd_irq` pulse in `clk` cycles (≥1).
- `GAP_LEN`, 16: idle cycles after a pop before the next byte is presented (≥1).

Ports:
- `clk` in 1: system clock (48 MHz).
- `rst` in 1: asynchronous, active-high reset.
- `main_wr` in 1: main-CPU write strobe, one `clk` cycle per byte.
- `main_din` in 8: command byte, sampled when `main_wr`=1.
- `snd_rd` in 1: sound-CPU latch read, level; this is the sound CPU's latch chip-select and may stay high for several cycles.
- `ovf_clr` in 1: clears the sticky `overflow` flag.
- `snd_latch` out 8: byte seen by the sound CPU.
- `snd_irq` out 1: NMI request pulse.
- `full` out 1: FIFO holds 2^AW bytes.
- `empty` out 1: FIFO holds 0 bytes.
- `count` out AW+1: current occupancy.
- `overflow` out 1: sticky flag, set when a write is dropped.

## Operation
- FIFO:
  - Circular buffer with read and write pointers of AW+1 bits; the MSB distinguishes full from empty.
  - `count` = wr_ptr − rd_ptr, modulo 2^(AW+1).
- Write:
  - When `main_wr`=1 and the FIFO is not full, store `main_din` at wr_ptr and increment wr_ptr.
  - When `main_wr`=1 and the FIFO is full, drop the byte and set `overflow`.
- `overflow` clears on `ovf_clr`. If a dropped write and `ovf_clr` occur in the same cycle, set wins.
- `snd_rd` is registered once (`rd_l`). Rise = `snd_rd & ~rd_l`; fall = `~snd_rd & rd_l`.
- State machine (one-hot or binary, implementer's choice):
  - IDLE: if not empty → PRESENT. Load `snd_latch` with the head byte, set `snd_irq`=1, load the pulse counter with IRQ_LEN.
  - PRESENT: decrement the counter. At 0 → WAIT_ACK with `snd_irq`=0. If a `snd_rd` fall occurs here → pop, `snd_irq`=0, go to GAP.
  - WAIT_ACK: on a `snd_rd` fall → pop (increment rd_ptr), go to GAP and load the gap counter with GAP_LEN.
  - GAP: decrement the counter. At 0 → IDLE.
- `snd_rd` edges in IDLE and GAP are ignored: no pop, and `snd_latch` keeps its last value. Repeated reads return the same byte, matching plain-latch behaviour.
- `snd_latch` holds the last presented byte until the next presentation; it never shows unpresented FIFO contents.
- A write and a pop in the same cycle are both performed; `count` is unchanged.
- Popping frees one slot in the same cycle, so a write in that cycle is accepted even when the FIFO was full.

## Timing
- Reset values:
  - `snd_latch`=8'h00, `snd_irq`=0.
  - `full`=0, `empty`=1, `count`=0, `overflow`=0.
  - State IDLE, pointers 0.
- Reset is asynchronous: asserting `rst` mid-pulse or mid-FIFO drops `snd_irq` and discards all buffered bytes immediately.
- Write-to-present latency when empty and IDLE:
  - Write in cycle N: `empty`=0 and `count`=1 in N+1, state PRESENT entered at the edge ending N+1.
  - `snd_latch` valid and `snd_irq`=1 from N+2.
  - `snd_irq` stays high for exactly IRQ_LEN cycles unless acknowledged earlier.
- Pop: a `snd_rd` falling at edge M is detected in cycle M+1 (registered). rd_ptr and `count` update at edge M+2.
- Next presentation, if the FIFO is still non-empty: `snd_irq` rises GAP_LEN+1 cycles after the pop edge. This guarantees `snd_irq` is low for at least GAP_LEN cycles between pulses, so the downstream edge detector always sees a fresh edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then a single write of 8'h5A at cycle 10:
  - `snd_latch`=8'h5A and `snd_irq`=1 in cycles 12–19 (IRQ_LEN=8).
  - `count`=1 until the read ends.
  - `snd_rd` high cycles 30–33 → `count`=0 at cycle 35, state IDLE after GAP.
- Burst of writes 01,02,03,04 in consecutive cycles, then a fifth write 05:
  - `full`=1, 05 dropped, `overflow`=1.
  - Four reads return 01..04 in order; each `snd_irq` rise is separated by ≥GAP_LEN low cycles.
- `snd_rd` falling during PRESENT (cycle 14):
  - `snd_irq` drops by cycle 15 and a pop occurs.
  - No second pulse for the same byte.
- FIFO full and a write coincident with a pop:
  - Write accepted, `count` stays 4, `overflow` unchanged.
- `snd_rd` toggling during GAP and during IDLE with an empty FIFO:
  - No pop, `count` unchanged, `snd_latch` holds its previous value.
- `rst` asserted while `snd_irq`=1 and `count`=3:
  - Immediate `snd_irq`=0, `count`=0, `snd_latch`=8'h00.
  - A write after reset is presented normally.
